// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin controller (one full-subtractor cell, LSB first); SERIAL_SUB_SAT_EN clamps diff to 0 on borrow.
// Latency WIDTH cycles from accept to out_valid; result is held in DONE until out_ready, in_ready low while busy.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             nb;
    logic [WIDTH-1:0] diff_nxt;
    logic [WIDTH-1:0] diff_fin;

    // Single-bit full subtractor on the current LSBs.
    assign d        = a_sh[0] ^ b_sh[0] ^ brw;
    assign nb       = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    assign diff_nxt = {d, diff_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
    assign diff_fin = nb ? '0 : diff_nxt;
`else
    assign diff_fin = diff_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        brw      <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_nxt;
                    brw     <= nb;
                    // cnt parks at LAST so it never wraps for power-of-two widths.
                    if (cnt == LAST) begin
                        out_valid  <= 1'b1;
                        diff       <= diff_fin;
                        borrow_out <= nb;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
